// File: rtl/mem_stage.sv
// Memory pipeline stage: passes non-memory instructions straight to write-back,
// rejects misaligned accesses, and runs one data-memory request at a time with
// an ack timeout.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_valid, result, store_data, flag, mem_read, mem_write, reg_write, write_reg
//                                EX-stage instruction inputs
//   stall                        EX/ID hold while a memory request is pending
//   mem_req, mem_we, mem_addr, mem_wdata / mem_rdata, mem_ack
//                                data-memory request / response
//   wb_valid, wb_data, wb_reg, wb_reg_write, wb_flag, wb_exc
//                                write-back outputs (wb_exc: 0 none, 1 misaligned, 2 bus error)
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] result,
    input  logic [31:0] store_data,
    input  logic [2:0]  flag,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_reg_write,
    output logic [2:0]  wb_flag,
    output logic [1:0]  wb_exc
);

    localparam int unsigned CNT_W = 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS   = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [4:0]       lat_reg_q, lat_reg_d;
    logic             lat_rw_q, lat_rw_d;
    logic [2:0]       lat_flag_q, lat_flag_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic             wb_rw_q, wb_rw_d;
    logic [2:0]       wb_flag_q, wb_flag_d;
    logic [1:0]       wb_exc_q, wb_exc_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_reg_q   <= '0;
            lat_rw_q    <= 1'b0;
            lat_flag_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
            wb_rw_q     <= 1'b0;
            wb_flag_q   <= '0;
            wb_exc_q    <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_reg_q   <= lat_reg_d;
            lat_rw_q    <= lat_rw_d;
            lat_flag_q  <= lat_flag_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_reg_q    <= wb_reg_d;
            wb_rw_q     <= wb_rw_d;
            wb_flag_q   <= wb_flag_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    // Next-state and output logic; wb_valid/wb_reg_write pulse only on completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_reg_d   = lat_reg_q;
        lat_rw_d    = lat_rw_q;
        lat_flag_d  = lat_flag_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_reg_d    = wb_reg_q;
        wb_rw_d     = 1'b0;
        wb_flag_d   = wb_flag_q;
        wb_exc_d    = wb_exc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!mem_read && !mem_write) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = result;
                        wb_reg_d   = write_reg;
                        wb_rw_d    = reg_write;
                        wb_flag_d  = flag;
                        wb_exc_d   = EXC_NONE;
                    end else if (result[1:0] != 2'b00) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = result;
                        wb_reg_d   = write_reg;
                        wb_flag_d  = flag;
                        wb_exc_d   = EXC_ALIGN;
                    end else begin
                        state_d     = S_WAIT;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = result;
                        mem_wdata_d = store_data;
                        lat_reg_d   = write_reg;
                        lat_rw_d    = reg_write;
                        lat_flag_d  = flag;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    // Ack is checked first so it beats a same-cycle timeout
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = lat_reg_q;
                    wb_flag_d  = lat_flag_q;
                    wb_exc_d   = EXC_NONE;
                    if (mem_we_q) begin
                        wb_data_d = mem_addr_q;
                        wb_rw_d   = 1'b0;
                    end else begin
                        wb_data_d = mem_rdata;
                        wb_rw_d   = lat_rw_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mem_addr_q;
                    wb_reg_d   = lat_reg_q;
                    wb_flag_d  = lat_flag_q;
                    wb_exc_d   = EXC_BUS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign stall        = (state_q == S_WAIT);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_reg       = wb_reg_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_flag      = wb_flag_q;
    assign wb_exc       = wb_exc_q;

endmodule
